// File: rtl/w5300_bus_arbiter.sv
// Round-robin owner arbiter for the shared W5300 host-bus command port; optional grant timeout via `W5300_ARB_TIMEOUT_EN.
// Latency: grant one cycle after an eligible req is sampled at an op boundary; addr/wr_data/op_state/rd_data muxing is combinational.
// Backpressure: non-owners wait with req held; ownership only changes when op_state=1, with one idle cycle between owners.
module w5300_bus_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*11-1:0]   req_addr,
    input  logic [NUM_REQ*16-1:0]   req_wr_data,
    output logic [NUM_REQ-1:0]      grant,
    output logic [NUM_REQ-1:0]      req_op_state,
    output logic [15:0]             req_rd_data,
    output logic [NUM_REQ-1:0]      timeout_err,
    output logic [10:0]             addr,
    output logic [15:0]             wr_data,
    input  logic [15:0]             rd_data,
    input  logic                    op_state
);
    localparam int IW = $clog2(NUM_REQ);
    // W5300 op encoding: RD = 0, WR = 1
    localparam logic        OP_RD    = 1'b0;
    localparam logic [10:0] IDLE_CMD = {OP_RD, 10'h3FE};

    typedef enum logic {S_IDLE, S_OWNED} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IW-1:0]      last_q, last_d;   // doubles as the owner index while in S_OWNED
    logic [NUM_REQ-1:0] elig;
    logic               win_vld;
    logic [IW-1:0]      win_idx;
    logic               owner_req;

`ifdef W5300_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [NUM_REQ-1:0] terr_q, terr_d;

    assign elig        = req & ~mask_q;
    assign timeout_err = terr_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT == 0);
    assign elig        = req;
    assign timeout_err = '0;
`endif

    assign owner_req    = req[last_q];
    assign grant        = grant_q;
    assign req_op_state = grant_q & {NUM_REQ{op_state}};
    assign req_rd_data  = rd_data;

    // Search from last+1 upward with wraparound; first eligible wins.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_vld && elig[(int'(last_q) + k) % NUM_REQ]) begin
                win_vld = 1'b1;
                win_idx = IW'((int'(last_q) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
`ifdef W5300_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        mask_d  = mask_q & req;
        terr_d  = terr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (op_state && win_vld) begin
                    state_d          = S_OWNED;
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    last_d           = win_idx;
`ifdef W5300_ARB_TIMEOUT_EN
                    cnt_d            = '0;
`endif
                end
            end
            S_OWNED: begin
`ifdef W5300_ARB_TIMEOUT_EN
                if (cnt_q != CW'(TIMEOUT)) begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
                if (op_state && !owner_req) begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
`ifdef W5300_ARB_TIMEOUT_EN
                else if (op_state && cnt_q == CW'(TIMEOUT)) begin
                    state_d        = S_IDLE;
                    grant_d        = '0;
                    terr_d[last_q] = 1'b1;
                    mask_d[last_q] = 1'b1;
                end
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_comb begin
        addr    = IDLE_CMD;
        wr_data = 16'h0000;
        if (state_q == S_OWNED) begin
            addr    = req_addr[11*last_q +: 11];
            wr_data = req_wr_data[16*last_q +: 16];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
`ifdef W5300_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            mask_q  <= '0;
            terr_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
`ifdef W5300_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            terr_q  <= terr_d;
`endif
        end
    end

endmodule

// File: tb/tb_w5300_bus_arbiter.sv
// Directed bench for w5300_bus_arbiter (NUM_REQ=4, TIMEOUT=8); covers both W5300_ARB_TIMEOUT_EN builds.
module tb_w5300_bus_arbiter;
    localparam logic [10:0] IDLE_CMD = 11'h3FE;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [43:0] req_addr;
    logic [63:0] req_wr_data;
    logic [3:0]  grant;
    logic [3:0]  req_op_state;
    logic [15:0] req_rd_data;
    logic [3:0]  timeout_err;
    logic [10:0] addr;
    logic [15:0] wr_data;
    logic [15:0] rd_data;
    logic        op_state;

    int n_chk  = 0;
    int n_fail = 0;

    w5300_bus_arbiter #(.NUM_REQ(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wr_data(req_wr_data),
        .grant(grant), .req_op_state(req_op_state), .req_rd_data(req_rd_data),
        .timeout_err(timeout_err), .addr(addr), .wr_data(wr_data),
        .rd_data(rd_data), .op_state(op_state)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input logic [3:0] req_during);
        rst = 1'b1;
        req = req_during;
        tick();
        rst = 1'b0;
    endtask

    int          order [4] = '{0, 1, 3, 0};
    logic [3:0]  exp_g;
    logic [3:0]  r;

    initial begin
        rst = 1'b0; req = '0; op_state = 1'b1; rd_data = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            req_addr[11*i +: 11]    = 11'h100 + 11'(i);
            req_wr_data[16*i +: 16] = 16'hA000 + 16'(i);
        end

        // reset state
        do_reset(4'b0000);
        check_eq("rst_grant", 32'(grant), 32'h0);
        check_eq("rst_terr", 32'(timeout_err), 32'h0);
        check_eq("rst_addr", 32'(addr), 32'(IDLE_CMD));
        check_eq("rst_wdat", 32'(wr_data), 32'h0);
        check_eq("rst_opst", 32'(req_op_state), 32'h0);

        // single requester 2
        req_addr[22 +: 11]    = 11'h208;
        req_wr_data[32 +: 16] = 16'h1234;
        req = 4'b0100;
        #1;
        check_eq("single_pre", 32'(grant), 32'h0);
        tick();
        check_eq("single_grant", 32'(grant), 32'h4);
        check_eq("single_addr", 32'(addr), 32'h208);
        check_eq("single_wdat", 32'(wr_data), 32'h1234);
        req = 4'b0000;
        tick();
        check_eq("single_rel", 32'(grant), 32'h0);
        check_eq("single_idle_addr", 32'(addr), 32'(IDLE_CMD));
        req_addr[22 +: 11]    = 11'h102;
        req_wr_data[32 +: 16] = 16'hA002;

        // simultaneous requests 4'b1011 from reset: order 0,1,3,0 with idle gaps
        do_reset(4'b1011);
        tick();
        r = 4'b1011;
        for (int n = 0; n < 4; n++) begin
            exp_g = 4'b0001 << order[n];
            for (int c = 0; c < 3; c++) begin
                check_eq($sformatf("rr%0d_grant", n), 32'(grant), 32'(exp_g));
                if (c == 0) begin
                    check_eq($sformatf("rr%0d_addr", n), 32'(addr), 32'h100 + 32'(order[n]));
                    check_eq($sformatf("rr%0d_wdat", n), 32'(wr_data), 32'hA000 + 32'(order[n]));
                end
                if (c == 2) req = r & ~exp_g;
                tick();
            end
            check_eq($sformatf("rr%0d_gap", n), 32'(grant), 32'h0);
            req = r;
            tick();
        end

        // mid-operation release by owner 1
        do_reset(4'b0000);
        req = 4'b0010;
        tick();
        check_eq("mid_grant", 32'(grant), 32'h2);
        op_state = 1'b0;
        req = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq($sformatf("mid_hold%0d", c), 32'(grant), 32'h2);
        end
        op_state = 1'b1;
        #1;
        check_eq("mid_hold_boundary", 32'(grant), 32'h2);
        tick();
        check_eq("mid_rel", 32'(grant), 32'h0);

        // op_state gating and rd_data broadcast with owner 0
        req = 4'b0001;
        tick();
        check_eq("gate_grant", 32'(grant), 32'h1);
        rd_data = 16'hBEEF;
        for (int c = 0; c < 4; c++) begin
            op_state = c[0];
            #1;
            check_eq($sformatf("gate_opst%0d", c), 32'(req_op_state), 32'({3'b000, op_state}));
        end
        check_eq("gate_rdat", 32'(req_rd_data), 32'hBEEF);
        op_state = 1'b1;
        req = 4'b0000;
        tick();
        check_eq("gate_rel", 32'(grant), 32'h0);

        // reset while owner 3 is active
        req = 4'b1000;
        tick();
        check_eq("rstmid_grant", 32'(grant), 32'h8);
        do_reset(4'b1000);
        check_eq("rstmid_g0", 32'(grant), 32'h0);
        check_eq("rstmid_terr", 32'(timeout_err), 32'h0);
        check_eq("rstmid_addr", 32'(addr), 32'(IDLE_CMD));
        req = 4'b1111;
        tick();
        check_eq("rstmid_first", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();

        // requester 1 held forever with op_state=1
        do_reset(4'b0000);
        req = 4'b0010;
        tick();
`ifdef W5300_ARB_TIMEOUT_EN
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("to_hold%0d", c), 32'(grant), 32'h2);
            tick();
        end
        check_eq("to_hold8", 32'(grant), 32'h2);
        tick();
        check_eq("to_revoke", 32'(grant), 32'h0);
        check_eq("to_err", 32'(timeout_err), 32'h2);
        tick(); tick();
        check_eq("to_masked", 32'(grant), 32'h0);
        req = 4'b0000;
        tick();
        req = 4'b0010;
        tick();
        check_eq("to_regrant", 32'(grant), 32'h2);
        check_eq("to_err_sticky", 32'(timeout_err), 32'h2);
`else
        for (int c = 0; c < 20; c++) tick();
        check_eq("noto_hold", 32'(grant), 32'h2);
        check_eq("noto_err", 32'(timeout_err), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/w5300_bus_arbiter.md
# w5300_bus_arbiter

Round-robin arbiter sharing the single W5300 host-bus command port (addr / wr_data / rd_data / op_state) among NUM_REQ socket engines (per-socket receivers, transmitters, the configuration sequencer). One requester owns the port at a time, for a whole multi-operation transaction. Ownership changes only at a bus-operation boundary. It sits between the socket engines and the W5300 bus-cycle driver.

## Interface
- NUM_REQ, 4: number of requesters, 2..8.
- TIMEOUT, 1024: maximum cycles one grant may be held; used only with W5300_ARB_TIMEOUT_EN.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req  in  NUM_REQ  per-requester ownership request; held high for the whole transaction.
- req_addr  in  NUM_REQ*11  per-requester command, {op bit (RD/WR from W5300 package), 10-bit register address}; slice i = bits [11*i+10:11*i].
- req_wr_data  in  NUM_REQ*16  per-requester write data; slice i = bits [16*i+15:16*i].
- grant  out  NUM_REQ  one-hot (or zero) ownership indication, registered.
- req_op_state  out  NUM_REQ  op_state gated to the owner: op_state & grant[i].
- req_rd_data  out  16  rd_data broadcast to all requesters.
- timeout_err  out  NUM_REQ  sticky per-requester timeout flag.
- addr  out  11  command to the bus driver.
- wr_data  out  16  write data to the bus driver.
- rd_data  in  16  read data from the bus driver.
- op_state  in  1  high while the bus driver is idle or has just completed an operation (operation boundary).

## Operation
- State machine: IDLE, OWNED.
- IDLE:
  - grant = 0.
  - addr = {RD, 10'h3FE}, wr_data = 16'h0000.
  - If op_state = 1 and any eligible req is high, pick the winner round-robin, searching from last+1 upward with wraparound. Then set grant[winner], store last = winner, and go to OWNED.
  - Eligible means req[i] = 1 and mask[i] = 0.
- OWNED (owner g):
  - addr = req_addr slice g, wr_data = req_wr_data slice g, combinationally.
  - req_op_state[g] = op_state; all others read 0.
  - When req[g] = 0 and op_state = 1, clear grant and go to IDLE.
  - If req[g] drops while op_state = 0, stay in OWNED until op_state = 1, so an in-flight operation is never cut off.
- Return to IDLE always costs one cycle, so back-to-back ownership has a one-cycle gap.
- Requests that rise while another requester owns the port wait. Simultaneous requests are resolved purely by the round-robin pointer.
- Reset:
  - Takes effect mid-transaction as well.
  - State returns to IDLE; grant, mask and timeout_err clear; last = NUM_REQ-1, so requester 0 has first priority.
  - The hold counter clears.
  - addr/wr_data show the idle command in the cycle after reset.

## Timing
- Grant latency: req high with op_state = 1 at edge t → grant high after edge t+1; the owner's command is on addr in that same cycle.
- Release: owner drops req with op_state = 1 at edge t → grant low after t+1. A pending requester is granted after t+2.
- Output decode:
  - req_op_state and req_rd_data are combinational from the bus, with zero latency.
  - addr and wr_data are combinational from grant plus the request buses.
- Hold counter:
  - $clog2(TIMEOUT+1) bits wide.
  - Counts cycles in OWNED and saturates at TIMEOUT.
  - Clears on entry to OWNED.

## Configuration
- W5300_ARB_TIMEOUT_EN defined:
  - If the hold counter reaches TIMEOUT while in OWNED, the arbiter revokes at the next op_state = 1: grant clears and the state returns to IDLE.
  - timeout_err[g] and mask[g] are set.
  - mask[g] clears once req[g] has been observed low. timeout_err[g] stays set until rst.
- W5300_ARB_TIMEOUT_EN undefined:
  - No counter and no mask; a grant is held indefinitely.
  - timeout_err is tied to 0.

## Test plan
- Single requester: rst, then req[2] = 1 with op_state = 1 → grant = 4'b0100 one cycle later. Drive req_addr slice 2 = 11'h208 → addr = 11'h208. Drop req[2] → grant = 0 next cycle, addr = {RD, 10'h3FE}.
- Simultaneous requests: req = 4'b1011 held from reset, each owner releasing after 3 operations → grant order 0, 1, 3, 0, each with a one-cycle gap in IDLE.
- Mid-operation release: owner 1 drops req while op_state = 0 for 5 cycles → grant[1] stays 1 until op_state rises, then clears one cycle later.
- Gating: owner 0 granted, op_state toggling → req_op_state = {0, 0, 0, op_state} exactly. rd_data = 16'hBEEF → req_rd_data = 16'hBEEF.
- Timeout (macro on, TIMEOUT = 8): req[1] held forever with op_state = 1 → grant[1] clears after 9 cycles in OWNED, timeout_err = 4'b0010. Requester 1 is not re-granted until req[1] has been low for one cycle.
- Reset mid-transaction: rst asserted while owner 3 is active → grant = 0, timeout_err = 0 next cycle. After reset, with all req high, first grant = 4'b0001.
